// File: rtl/divisor_pkg.sv
// Shared types for the shared-divider arbiter.
// FSM states, status codes and the default watchdog length.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ZERO    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  function automatic int default_timeout(input int w);
    return 4 * w + 8;
  endfunction

endpackage

// File: rtl/rr_arbitro.sv
// Combinational round-robin search: first set request
// at or above ptr, wrapping around.
module rr_arbitro #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = IW'((int'(ptr) + i) % N_REQ);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/divisor_arbitro.sv
// Shares one sequential divider among N_REQ clients:
// round-robin grant, zero-divisor bypass, watchdog abort.
module divisor_arbitro
  import divisor_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int tamanyo = 32,
  parameter int TIMEOUT = default_timeout(tamanyo)
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*tamanyo-1:0]   Num,
  input  logic [N_REQ*tamanyo-1:0]   Den,
  output logic [N_REQ-1:0]           Ack,
  output logic [tamanyo-1:0]         Coc_Out,
  output logic [tamanyo-1:0]         Res_Out,
  output logic [1:0]                 Err_Code,
  output logic [$clog2(N_REQ)-1:0]   Grant_Id,
  output logic                       Busy,
  output logic                       Div_Start,
  output logic [tamanyo-1:0]         Div_Num,
  output logic [tamanyo-1:0]         Div_Den,
  input  logic                       Div_Done,
  input  logic [tamanyo-1:0]         Div_Coc,
  input  logic [tamanyo-1:0]         Div_Res
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 2);

  state_t               state_q, state_d;
  err_t                 err_q, err_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [tamanyo-1:0]   coc_q, coc_d;
  logic [tamanyo-1:0]   res_q, res_d;
  logic [tamanyo-1:0]   num_q, num_d;
  logic [tamanyo-1:0]   den_q, den_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;

  logic                 arb_valid;
  logic [IW-1:0]        arb_idx;
  logic [tamanyo-1:0]   num_a [N_REQ];
  logic [tamanyo-1:0]   den_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign num_a[g] = Num[g*tamanyo +: tamanyo];
    assign den_a[g] = Den[g*tamanyo +: tamanyo];
  end

  rr_arbitro #(.N_REQ(N_REQ)) u_rr (
    .req   (Req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    coc_d   = coc_q;
    res_d   = res_q;
    num_d   = num_q;
    den_d   = den_q;
    wd_d    = wd_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          num_d   = num_a[arb_idx];
          den_d   = den_a[arb_idx];
          // Zero divisor never reaches the divider.
          if (den_a[arb_idx] == '0) begin
            coc_d   = '1;
            res_d   = num_a[arb_idx];
            err_d   = ERR_ZERO;
            state_d = RESP;
          end else begin
            start_d = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (Div_Done) begin
          coc_d   = Div_Coc;
          res_d   = Div_Res;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          coc_d   = '0;
          res_d   = '0;
          err_d   = ERR_TIMEOUT;
          state_d = RESP;
        end
      end
      RESP: begin
        ack_d[grant_q] = 1'b1;
        ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      state_q <= IDLE;
      err_q   <= ERR_OK;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      num_q   <= num_d;
      den_q   <= den_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign Ack       = ack_q;
  assign Coc_Out   = coc_q;
  assign Res_Out   = res_q;
  assign Err_Code  = err_q;
  assign Grant_Id  = grant_q;
  assign Busy      = busy_q;
  assign Div_Start = start_q;
  assign Div_Num   = num_q;
  assign Div_Den   = den_q;

endmodule

// File: tb/tb_divisor_arbitro.sv
// Directed bench for divisor_arbitro with a behavioural
// divider of programmable latency.
module tb_divisor_arbitro;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 4 * W + 8;

  logic           CLK  = 1'b0;
  logic           RSTa = 1'b1;
  logic [N-1:0]   Req  = '0;
  logic [N*W-1:0] Num  = '0;
  logic [N*W-1:0] Den  = '0;
  logic [N-1:0]   Ack;
  logic [W-1:0]   Coc_Out, Res_Out;
  logic [1:0]     Err_Code;
  logic [1:0]     Grant_Id;
  logic           Busy, Div_Start;
  logic [W-1:0]   Div_Num, Div_Den;
  logic           Div_Done = 1'b0;
  logic [W-1:0]   Div_Coc  = '0;
  logic [W-1:0]   Div_Res  = '0;

  int n_assert = 0;
  int n_fail   = 0;

  int d_cnt    = 0;
  bit d_act    = 0;
  bit div_hang = 0;
  int div_lat  = 34;
  bit inject   = 0;

  divisor_arbitro #(.N_REQ(N), .tamanyo(W)) dut (
    .CLK(CLK), .RSTa(RSTa), .Req(Req), .Num(Num), .Den(Den),
    .Ack(Ack), .Coc_Out(Coc_Out), .Res_Out(Res_Out),
    .Err_Code(Err_Code), .Grant_Id(Grant_Id), .Busy(Busy),
    .Div_Start(Div_Start), .Div_Num(Div_Num), .Div_Den(Div_Den),
    .Div_Done(Div_Done), .Div_Coc(Div_Coc), .Div_Res(Div_Res)
  );

  always #5 CLK = ~CLK;

  // Divider: Done exactly div_lat cycles after the Start cycle.
  always @(posedge CLK) begin
    #1;
    Div_Done = 1'b0;
    if (RSTa) begin
      d_act = 0;
    end else if (Div_Start) begin
      d_act = !div_hang;
      d_cnt = div_lat;
    end else if (d_act) begin
      d_cnt--;
      if (d_cnt == 0) begin
        d_act    = 0;
        Div_Done = 1'b1;
        if (Div_Den != '0) begin
          Div_Coc = $signed(Div_Num) / $signed(Div_Den);
          Div_Res = $signed(Div_Num) % $signed(Div_Den);
        end
      end
    end
    if (inject) begin
      Div_Done = 1'b1;
      Div_Coc  = 32'h1234;
      Div_Res  = 32'h5678;
      inject   = 0;
    end
  end

  task automatic do_reset();
    RSTa = 1'b1;
    Req  = '0;
    repeat (2) @(negedge CLK);
    RSTa = 1'b0;
    @(negedge CLK);
  endtask

  // Raise Req[idx] now (at a negedge); returns when Ack seen.
  task automatic run_req(input int idx, input int maxc,
                         input bit drop_early,
                         output int ack_cyc, output int n_start,
                         output int st_cyc,
                         output logic [W-1:0] st_num,
                         output logic [W-1:0] st_den);
    ack_cyc = -1;
    n_start = 0;
    st_cyc  = -1;
    st_num  = 'x;
    st_den  = 'x;
    Req[idx] = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge CLK);
      if (drop_early && c == 1) Req[idx] = 1'b0;
      if (Div_Start === 1'b1) begin
        n_start++;
        if (st_cyc < 0) begin
          st_cyc = c;
          st_num = Div_Num;
          st_den = Div_Den;
        end
      end
      if (Ack !== '0) begin
        ack_cyc = c;
        break;
      end
    end
    Req[idx] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_assert++;
    if ({Ack, Busy, Div_Start, Err_Code, Grant_Id} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp 0",
               {Ack, Busy, Div_Start, Err_Code, Grant_Id});
    end
    n_assert++;
    if ({Coc_Out, Res_Out} !== '0) begin
      n_fail++;
      $display("FAIL reset_res got %h %h exp 0", Coc_Out, Res_Out);
    end
    n_assert++;
    if ({Div_Num, Div_Den} !== '0) begin
      n_fail++;
      $display("FAIL reset_div got %h %h exp 0", Div_Num, Div_Den);
    end
    RSTa = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int ac, ns, sc;
    logic [W-1:0] sn, sd;
    div_lat = 34;
    Num[0 +: W] = 32'd100;
    Den[0 +: W] = 32'd7;
    run_req(0, 100, 0, ac, ns, sc, sn, sd);
    n_assert++;
    if (ns !== 1 || sc !== 1) begin
      n_fail++;
      $display("FAIL single_start got n=%0d cyc=%0d exp 1 1", ns, sc);
    end
    n_assert++;
    if (sn !== 32'd100 || sd !== 32'd7) begin
      n_fail++;
      $display("FAIL single_opnds got %0d %0d exp 100 7", sn, sd);
    end
    n_assert++;
    if (ac !== 37) begin
      n_fail++;
      $display("FAIL single_latency got %0d exp 37", ac);
    end
    n_assert++;
    if (Ack !== 4'b0001 || Grant_Id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_ack got %b/%0d exp 0001/0", Ack, Grant_Id);
    end
    n_assert++;
    if (Coc_Out !== 32'd14 || Res_Out !== 32'd2 || Err_Code !== 2'b00) begin
      n_fail++;
      $display("FAIL single_result got %0d r%0d e%b exp 14 r2 e00",
               Coc_Out, Res_Out, Err_Code);
    end
    @(negedge CLK);
    n_assert++;
    if (Ack !== 4'b0000 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse got ack=%b busy=%b exp 0000 0", Ack, Busy);
    end
  endtask

  task automatic test_round_robin();
    int ord [6] = '{0, 1, 2, 3, 0, 2};
    logic [W-1:0] qc [4] = '{32'd6, 32'd7, 32'd8, 32'd8};
    logic [W-1:0] qr [4] = '{32'd2, 32'd2, 32'd0, 32'd2};
    int k, e;
    do_reset();
    div_lat = 3;
    for (int i = 0; i < N; i++) begin
      Num[i*W +: W] = W'(20 + 10 * i);
      Den[i*W +: W] = W'(i + 3);
    end
    k = 0;
    Req = 4'b1111;
    for (int c = 0; c < 200 && k < 6; c++) begin
      @(negedge CLK);
      if (Ack !== '0) begin
        e = ord[k];
        n_assert++;
        if (Ack !== 4'(1 << e) || Grant_Id !== 2'(e)) begin
          n_fail++;
          $display("FAIL rr_order[%0d] got %b/%0d exp req %0d",
                   k, Ack, Grant_Id, e);
        end
        n_assert++;
        if (Coc_Out !== qc[e] || Res_Out !== qr[e]) begin
          n_fail++;
          $display("FAIL rr_result[%0d] got %0d r%0d exp %0d r%0d",
                   k, Coc_Out, Res_Out, qc[e], qr[e]);
        end
        Req = Req & ~Ack;
        k++;
        if (k == 4) Req = 4'b0101;
      end
    end
    Req = '0;
    n_assert++;
    if (k !== 6) begin
      n_fail++;
      $display("FAIL rr_count got %0d exp 6", k);
    end
  endtask

  task automatic test_timeout();
    int ac, ns, sc;
    logic [W-1:0] sn, sd;
    div_hang = 1;
    Num[1*W +: W] = 32'd9;
    Den[1*W +: W] = 32'd2;
    run_req(1, 200, 0, ac, ns, sc, sn, sd);
    n_assert++;
    if (ac !== TO + 2 || ns !== 1) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d starts=%0d exp %0d 1",
               ac, ns, TO + 2);
    end
    n_assert++;
    if (Ack !== 4'b0010 || Err_Code !== 2'b10 ||
        Coc_Out !== '0 || Res_Out !== '0) begin
      n_fail++;
      $display("FAIL timeout_result got %b e%b %h %h exp 0010 e10 0 0",
               Ack, Err_Code, Coc_Out, Res_Out);
    end
    inject = 1;
    repeat (3) @(negedge CLK);
    n_assert++;
    if (Ack !== '0 || Busy !== 1'b0 || Err_Code !== 2'b10 ||
        Coc_Out !== '0 || Res_Out !== '0) begin
      n_fail++;
      $display("FAIL late_done got %b %b e%b %h %h exp unchanged",
               Ack, Busy, Err_Code, Coc_Out, Res_Out);
    end
    div_hang = 0;
  endtask

  task automatic test_zero_div();
    int ac, ns, sc;
    logic [W-1:0] sn, sd;
    Num[2*W +: W] = 32'hFFFF_FFFB;
    Den[2*W +: W] = '0;
    inject = 1;
    run_req(2, 20, 0, ac, ns, sc, sn, sd);
    n_assert++;
    if (ns !== 0 || ac !== 2) begin
      n_fail++;
      $display("FAIL zero_timing got starts=%0d ack=%0d exp 0 2", ns, ac);
    end
    n_assert++;
    if (Ack !== 4'b0100 || Grant_Id !== 2'd2 || Err_Code !== 2'b01) begin
      n_fail++;
      $display("FAIL zero_ack got %b/%0d e%b exp 0100/2 e01",
               Ack, Grant_Id, Err_Code);
    end
    n_assert++;
    if (Coc_Out !== 32'hFFFF_FFFF || Res_Out !== 32'hFFFF_FFFB) begin
      n_fail++;
      $display("FAIL zero_result got %h %h exp ffffffff fffffffb",
               Coc_Out, Res_Out);
    end
  endtask

  task automatic test_reset_mid_wait();
    int ac, ns, sc, acks;
    logic [W-1:0] sn, sd;
    div_lat = 50;
    Num[3*W +: W] = 32'd77;
    Den[3*W +: W] = 32'd5;
    Req[3] = 1'b1;
    repeat (10) @(negedge CLK);
    RSTa = 1'b1;
    Req  = '0;
    #1;
    n_assert++;
    if ({Busy, Err_Code, Grant_Id, Ack} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_ctl got %b exp 0",
               {Busy, Err_Code, Grant_Id, Ack});
    end
    n_assert++;
    if ({Coc_Out, Res_Out, Div_Num, Div_Den} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_data got %h %h %h %h exp 0",
               Coc_Out, Res_Out, Div_Num, Div_Den);
    end
    repeat (2) @(negedge CLK);
    RSTa = 1'b0;
    acks = 0;
    repeat (60) begin
      @(negedge CLK);
      if (Ack !== '0) acks++;
    end
    n_assert++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL rst_no_ack got %0d acks exp 0", acks);
    end
    div_lat = 5;
    run_req(3, 50, 0, ac, ns, sc, sn, sd);
    n_assert++;
    if (ac !== 8 || Ack !== 4'b1000 || Grant_Id !== 2'd3 ||
        Coc_Out !== 32'd15 || Res_Out !== 32'd2) begin
      n_fail++;
      $display("FAIL rst_recover got c%0d %b/%0d %0d r%0d exp c8 1000/3 15 r2",
               ac, Ack, Grant_Id, Coc_Out, Res_Out);
    end
  endtask

  task automatic test_back_to_back();
    int ac, ns, sc, n_ack;
    int ac_cyc [2];
    logic [W-1:0] sn, sd;
    div_lat = 4;
    Num[1*W +: W] = 32'hFFFF_FFEC;
    Den[1*W +: W] = 32'd3;
    run_req(1, 50, 1, ac, ns, sc, sn, sd);
    n_assert++;
    if (ac !== 7 || Ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_ack got c%0d %b exp c7 0010", ac, Ack);
    end
    n_assert++;
    if (Coc_Out !== 32'hFFFF_FFFA || Res_Out !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL drop_result got %h %h exp fffffffa fffffffe",
               Coc_Out, Res_Out);
    end
    @(negedge CLK);
    div_lat = 2;
    Num[0 +: W] = 32'd50;
    Den[0 +: W] = 32'd7;
    n_ack = 0;
    ac_cyc = '{-1, -1};
    Req[0] = 1'b1;
    for (int c = 1; c <= 40 && n_ack < 2; c++) begin
      @(negedge CLK);
      if (Ack !== '0) begin
        ac_cyc[n_ack] = c;
        n_ack++;
      end
    end
    Req = '0;
    n_assert++;
    if (ac_cyc[0] !== 5 || ac_cyc[1] !== 10) begin
      n_fail++;
      $display("FAIL held_req got acks at %0d,%0d exp 5,10",
               ac_cyc[0], ac_cyc[1]);
    end
    n_assert++;
    if (Coc_Out !== 32'd7 || Res_Out !== 32'd1 || Ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL held_result got %0d r%0d %b exp 7 r1 0001",
               Coc_Out, Res_Out, Ack);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_zero_div();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
